// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the instruction decoder and the MCU execute stage.
//   state_e          : decoder FSM states (opcode fetch / operand collection)
//   DEF_*            : default decoder geometry
//   OPC_*            : default opcode map (opcodes 1..4 carry an operand)
//   onehot64()       : opcode index to one-hot helper, truncated by the caller
// -----------------------------------------------------------------------------
package decode_pkg;

   typedef enum logic {
      ST_OPCODE  = 1'b0,
      ST_OPERAND = 1'b1
   } state_e;

   localparam int DEF_INST_W   = 8;
   localparam int DEF_CMD_NUM  = 40;
   localparam int DEF_IMM_BASE = 1;
   localparam int DEF_IMM_NUM  = 4;
   localparam int DEF_IMM_LEN  = 1;

   localparam logic [7:0] OPC_NOP  = 8'h00;
   localparam logic [7:0] OPC_LDI  = 8'h01;
   localparam logic [7:0] OPC_ADDI = 8'h02;
   localparam logic [7:0] OPC_ANDI = 8'h03;
   localparam logic [7:0] OPC_JMPI = 8'h04;
   localparam logic [7:0] OPC_HALT = 8'h05;

   function automatic logic [63:0] onehot64(input logic [5:0] idx);
      onehot64 = 64'd1 << idx;
   endfunction

endpackage

// File: rtl/inst_decoder_if.sv
// -----------------------------------------------------------------------------
// inst_decoder_if
// Byte-stream input and decoded-command output of the instruction decoder.
//   inst_valid/inst/inst_ready       : incoming opcode/operand bytes
//   cmd_valid/cmd_ready/cmd/cmd_data : decoded one-hot command and operand
//   illegal                          : one-cycle pulse on an out-of-range opcode
//   cmd_cnt                          : issued-command counter
// Modports: slave (decoder side), master (byte source / command consumer).
// -----------------------------------------------------------------------------
interface inst_decoder_if #(
   parameter int INST_W  = 8,
   parameter int CMD_NUM = 40,
   parameter int IMM_LEN = 1
);
   logic                        inst_valid;
   logic [INST_W-1:0]           inst;
   logic                        inst_ready;
   logic                        cmd_valid;
   logic                        cmd_ready;
   logic [CMD_NUM-1:0]          cmd;
   logic [IMM_LEN*INST_W-1:0]   cmd_data;
   logic                        illegal;
   logic [15:0]                 cmd_cnt;

   modport slave (
      input  inst_valid, inst, cmd_ready,
      output inst_ready, cmd_valid, cmd, cmd_data, illegal, cmd_cnt
   );

   modport master (
      output inst_valid, inst, cmd_ready,
      input  inst_ready, cmd_valid, cmd, cmd_data, illegal, cmd_cnt
   );
endinterface

// File: rtl/decode_imm_acc.sv
// -----------------------------------------------------------------------------
// decode_imm_acc
// Operand assembler: byte counter plus lane-write register. Byte k of an
// operand lands in lane k (first byte = LSB).
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart assembly (new operand opcode or flush)
//   wr       : accept din into the current lane
//   din      : operand byte
//   last     : current lane is the final one
//   full     : stored lanes with din merged into the current lane, so the
//              complete operand is available in the cycle its last byte arrives
// -----------------------------------------------------------------------------
module decode_imm_acc #(
   parameter int INST_W  = 8,
   parameter int IMM_LEN = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      wr,
   input  logic [INST_W-1:0]         din,
   output logic                      last,
   output logic [IMM_LEN*INST_W-1:0] full
);
   localparam int KW = (IMM_LEN > 1) ? $clog2(IMM_LEN) : 1;
   localparam int DW = IMM_LEN * INST_W;

   logic [KW-1:0] k_q, k_d;
   logic [DW-1:0] acc_q, acc_d;

   always_comb begin
      last = (k_q == KW'(IMM_LEN - 1));
      full = acc_q;
      for (int lane = 0; lane < IMM_LEN; lane++) begin
         if (k_q == KW'(lane)) full[lane*INST_W +: INST_W] = din;
      end
      k_d   = k_q;
      acc_d = acc_q;
      if (clr) begin
         k_d   = '0;
         acc_d = '0;
      end else if (wr) begin
         acc_d = full;
         k_d   = last ? '0 : k_q + KW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k_q   <= '0;
         acc_q <= '0;
      end else begin
         k_q   <= k_d;
         acc_q <= acc_d;
      end
   end
endmodule

// File: rtl/inst_decoder.sv
// -----------------------------------------------------------------------------
// inst_decoder
// Byte-stream instruction decoder. Opcodes become one-hot commands; opcodes in
// [IMM_BASE, IMM_BASE+IMM_NUM) first collect IMM_LEN operand bytes.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, overrides everything
//   flush : abort partial instruction and pending command, drop offered byte
//   bus   : inst_decoder_if.slave (byte input, command output, illegal, cmd_cnt)
// Optional feature: define INST_DECODER_CNT_EN to build the saturating
// issued-command counter; otherwise cmd_cnt is tied to zero.
// -----------------------------------------------------------------------------
module inst_decoder
   import decode_pkg::*;
#(
   parameter int INST_W   = DEF_INST_W,
   parameter int CMD_NUM  = DEF_CMD_NUM,
   parameter int IMM_BASE = DEF_IMM_BASE,
   parameter int IMM_NUM  = DEF_IMM_NUM,
   parameter int IMM_LEN  = DEF_IMM_LEN
) (
   input logic           clk,
   input logic           rst,
   input logic           flush,
   inst_decoder_if.slave bus
);
   localparam int DW = IMM_LEN * INST_W;

   state_e             state_q, state_d;
   logic [5:0]         op_q, op_d;
   logic               cmd_valid_q, cmd_valid_d;
   logic [CMD_NUM-1:0] cmd_q, cmd_d;
   logic [DW-1:0]      data_q, data_d;
   logic               illegal_q, illegal_d;

   logic          accept, imm_clr, imm_wr, imm_last;
   logic [DW-1:0] imm_full;
   int            opc_i;
   logic          is_imm, is_legal, done;
   logic [5:0]    done_op;
   logic [DW-1:0] done_data;

   // Ready only depends on the output slot, never on flush, so the source
   // sees a stable handshake; flush simply makes the byte a no-op.
   assign bus.inst_ready = !cmd_valid_q || bus.cmd_ready;
   assign accept         = bus.inst_valid && bus.inst_ready && !flush;
   assign imm_wr         = accept && (state_q == ST_OPERAND);
   assign imm_clr        = flush || (accept && (state_q == ST_OPCODE) && is_imm);

   always_comb begin
      opc_i    = int'(bus.inst);
      is_imm   = (opc_i >= IMM_BASE) && (opc_i < IMM_BASE + IMM_NUM);
      is_legal = (opc_i < CMD_NUM);
   end

   decode_imm_acc #(
      .INST_W (INST_W),
      .IMM_LEN(IMM_LEN)
   ) u_imm_acc (
      .clk (clk),
      .rst (rst),
      .clr (imm_clr),
      .wr  (imm_wr),
      .din (bus.inst),
      .last(imm_last),
      .full(imm_full)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      illegal_d = 1'b0;
      done      = 1'b0;
      done_op   = op_q;
      done_data = '0;
      unique case (state_q)
         ST_OPCODE: begin
            if (accept) begin
               if (is_imm) begin
                  op_d    = 6'(opc_i);
                  state_d = ST_OPERAND;
               end else if (is_legal) begin
                  done    = 1'b1;
                  done_op = 6'(opc_i);
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         ST_OPERAND: begin
            // Bytes here are always operand data, never inspected as opcodes.
            if (accept && imm_last) begin
               done      = 1'b1;
               done_data = imm_full;
               state_d   = ST_OPCODE;
            end
         end
         default: state_d = ST_OPCODE;
      endcase
      if (flush) state_d = ST_OPCODE;

      // Output slot: a completing instruction refills it in the same cycle the
      // old command leaves, so back-to-back commands have no bubble.
      cmd_valid_d = cmd_valid_q;
      cmd_d       = cmd_q;
      data_d      = data_q;
      if (flush) begin
         cmd_valid_d = 1'b0;
         cmd_d       = '0;
         data_d      = '0;
      end else if (done) begin
         cmd_valid_d = 1'b1;
         cmd_d       = CMD_NUM'(onehot64(done_op));
         data_d      = done_data;
      end else if (cmd_valid_q && bus.cmd_ready) begin
         cmd_valid_d = 1'b0;
         cmd_d       = '0;
         data_d      = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_OPCODE;
         op_q        <= '0;
         cmd_valid_q <= 1'b0;
         cmd_q       <= '0;
         data_q      <= '0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_q       <= cmd_d;
         data_q      <= data_d;
         illegal_q   <= illegal_d;
      end
   end

   assign bus.cmd_valid = cmd_valid_q;
   assign bus.cmd       = cmd_q;
   assign bus.cmd_data  = data_q;
   assign bus.illegal   = illegal_q;

`ifdef INST_DECODER_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   // A flushed command is discarded, not consumed, so it is not counted.
   always_comb begin
      cnt_d = cnt_q;
      if (cmd_valid_q && bus.cmd_ready && !flush && (cnt_q != 16'hFFFF))
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign bus.cmd_cnt = cnt_q;
`else
   assign bus.cmd_cnt = '0;
`endif
endmodule
